// File: rtl/mips_pkg.sv
// Shared MIPS-Lite decode constants and multiplier FSM state type.
package mips_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } mul_state_e;

  // True for any funct that touches the HI/LO unit.
  function automatic logic is_hilo_funct(input logic [5:0] funct);
    return (funct == FUNCT_MULTU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

endpackage

// File: rtl/ex_multu_unit_shift_add.sv
// Radix-2 shift-add datapath: multiplicand register, product/multiplier
// register and the WIDTH+1 bit adder that keeps the carry on each shift.
module multu_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     sum;

  // Conditional add of the multiplicand, then shift right keeping the carry.
  always_comb begin
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    prod_next = {sum, prod_q[WIDTH-1:1]};
  end

  // Next-state selection: load operands on start, advance one bit per step.
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (load) begin
      mcand_d = op_a;
      prod_d  = {{WIDTH{1'b0}}, op_b};
    end else if (step) begin
      prod_d  = prod_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/ex_multu_unit.sv
// EX-stage unsigned multiplier: control FSM, step counter, HI/LO and the
// stall / MFHI / MFLO decode for hazard control and writeback.
module ex_multu_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               load, step, start;
  logic [2*WIDTH-1:0] prod_next;

  multu_shift_add #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst),
    .load      (load),
    .step      (step),
    .op_a      (op_a),
    .op_b      (op_b),
    .prod_next (prod_next)
  );

  assign busy  = (state_q == ST_MUL);
  assign start = en & (funct == FUNCT_MULTU) & ~busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Next-state, counter and HI/LO commit on the final step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = prod_next[2*WIDTH-1:WIDTH];
          lo_d    = prod_next[WIDTH-1:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Hazard and move-from decode; mf_valid is held low while in reset.
  always_comb begin
    stall    = en & busy & is_hilo_funct(funct);
    mf_valid = rst & en & ~busy & ((funct == FUNCT_MFHI) | (funct == FUNCT_MFLO));
    mf_data  = '0;
    if (funct == FUNCT_MFHI) begin
      mf_data = hi_q;
    end else if (funct == FUNCT_MFLO) begin
      mf_data = lo_q;
    end
  end

endmodule
